// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Brief   : Shared widths, NOP encoding and fetch state type for the IF stage.
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int PC_W   = 5;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module  : imem_ram
// Brief   : Instruction memory, synchronous write and asynchronous read.
// Revision: 1.0 - initial release
// ============================================================================
module imem_ram #(
  parameter int ADDR_W = mips_pkg::PC_W,
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // No reset: the program must survive a core reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mips_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : mips_fetch_stage
// Brief   : PC, redirect/stall control and bubble insertion feeding IF/ID.
// Revision: 1.0 - initial release
// ============================================================================
module mips_fetch_stage #(
  parameter int                 PC_W   = mips_pkg::PC_W,
  parameter int                 DATA_W = mips_pkg::DATA_W,
  parameter logic [DATA_W-1:0]  NOP    = mips_pkg::NOP,
  parameter int                 CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic              jump,
  input  logic [PC_W-1:0]   jump_target,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  output logic [DATA_W-1:0] instruccion,
  output logic [PC_W-1:0]   PC_next,
  output logic              if_id_en,
  output logic              fetch_valid,
  output logic [CNT_W-1:0]  fetch_count
);

  import mips_pkg::*;

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;

  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_target;
  logic              w_redirect;
  logic              w_run;
  logic [DATA_W-1:0] w_rdata;

  imem_ram #(
    .ADDR_W (PC_W),
    .DATA_W (DATA_W)
  ) u_imem (
    .clk     (clk),
    .i_we    (imem_we),
    .i_waddr (imem_waddr),
    .i_wdata (imem_wdata),
    .i_raddr (r_pc),
    .o_rdata (w_rdata)
  );

  assign w_pc_inc   = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_redirect = jump | branch_taken;
  assign w_target   = jump ? jump_target : branch_target;

  // Redirects take effect from any state; BOOT and FLUSH otherwise last one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc    <= '0;
      r_state <= BOOT;
      r_cnt   <= '0;
    end else if (w_redirect) begin
      r_pc    <= w_target;
      r_state <= FLUSH;
    end else if (r_state == RUN) begin
      if (!stall) begin
        r_pc <= w_pc_inc;
        if (r_cnt != {CNT_W{1'b1}}) begin
          r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      r_state <= RUN;
    end
  end

  // Reset is applied combinationally here so IF/ID is flushed while held.
  assign w_run       = reset & (r_state == RUN);
  assign instruccion = w_run ? w_rdata : NOP;
  assign PC_next     = reset ? w_pc_inc : '0;
  assign fetch_valid = w_run;
  assign if_id_en    = ~stall | jump | branch_taken | ~reset;
  assign fetch_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips_fetch_stage
// Brief   : Directed table-driven bench for the instruction-fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [4:0]  branch_target;
  logic        jump;
  logic [4:0]  jump_target;
  logic        imem_we;
  logic [4:0]  imem_waddr;
  logic [31:0] imem_wdata;

  logic [31:0] instruccion;
  logic [4:0]  PC_next;
  logic        if_id_en;
  logic        fetch_valid;
  logic [15:0] fetch_count;

  logic [31:0] s_instr;
  logic [4:0]  s_pcn;
  logic        s_en;
  logic        s_val;
  logic [2:0]  s_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_fetch_stage dut (
    .clk (clk), .reset (reset), .stall (stall),
    .branch_taken (branch_taken), .branch_target (branch_target),
    .jump (jump), .jump_target (jump_target),
    .imem_we (imem_we), .imem_waddr (imem_waddr), .imem_wdata (imem_wdata),
    .instruccion (instruccion), .PC_next (PC_next), .if_id_en (if_id_en),
    .fetch_valid (fetch_valid), .fetch_count (fetch_count)
  );

  // Narrow counter copy to reach saturation within a short run.
  mips_fetch_stage #(.CNT_W(3)) dut_sat (
    .clk (clk), .reset (reset), .stall (stall),
    .branch_taken (branch_taken), .branch_target (branch_target),
    .jump (jump), .jump_target (jump_target),
    .imem_we (imem_we), .imem_waddr (imem_waddr), .imem_wdata (imem_wdata),
    .instruccion (s_instr), .PC_next (s_pcn), .if_id_en (s_en),
    .fetch_valid (s_val), .fetch_count (s_cnt)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [4:0]  bt;
    logic        jmp;
    logic [4:0]  jt;
    logic [31:0] instr;
    logic [4:0]  pcn;
    logic        en;
    logic        val;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic st, logic br, logic [4:0] bt, logic jmp,
                              logic [4:0] jt, logic [31:0] ins, logic [4:0] pcn,
                              logic en, logic val, logic [15:0] cnt);
    vec_t v;
    v.stall = st; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt;
    v.instr = ins; v.pcn = pcn; v.en = en; v.val = val; v.cnt = cnt;
    return v;
  endfunction

  function automatic logic [31:0] mem_init(int i);
    if (i < 4) return 32'h11 * (i + 1);
    return 32'hA000_0000 + i;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string nm, logic [31:0] ins, logic [4:0] pcn,
                         logic en, logic val, logic [15:0] cnt);
    chk({nm, ".instr"}, instruccion, ins);
    chk({nm, ".pc_next"}, {27'd0, PC_next}, {27'd0, pcn});
    chk({nm, ".if_id_en"}, {31'd0, if_id_en}, {31'd0, en});
    chk({nm, ".valid"}, {31'd0, fetch_valid}, {31'd0, val});
    chk({nm, ".count"}, {16'd0, fetch_count}, {16'd0, cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;

    // stall, br, bt, jmp, jt, instr, pc_next, en, valid, count
    tbl.push_back(mk(0,0, 0,0, 0, 32'h0,         1,1,0, 0));
    tbl.push_back(mk(0,0, 0,0, 0, 32'h11,        1,1,1, 0));
    tbl.push_back(mk(0,0, 0,0, 0, 32'h22,        2,1,1, 1));
    tbl.push_back(mk(0,0, 0,0, 0, 32'h33,        3,1,1, 2));
    tbl.push_back(mk(0,0, 0,0, 0, 32'h44,        4,1,1, 3));
    tbl.push_back(mk(0,0, 0,1, 2, 32'hA000_0004, 5,1,1, 4));
    tbl.push_back(mk(0,0, 0,0, 0, 32'h0,         3,1,0, 4));
    tbl.push_back(mk(1,0, 0,0, 0, 32'h33,        3,0,1, 4));
    tbl.push_back(mk(1,0, 0,0, 0, 32'h33,        3,0,1, 4));
    tbl.push_back(mk(1,0, 0,0, 0, 32'h33,        3,0,1, 4));
    tbl.push_back(mk(0,0, 0,0, 0, 32'h33,        3,1,1, 4));
    tbl.push_back(mk(0,0, 0,0, 0, 32'h44,        4,1,1, 5));
    tbl.push_back(mk(0,0, 0,1, 1, 32'hA000_0004, 5,1,1, 6));
    tbl.push_back(mk(0,0, 0,0, 0, 32'h0,         2,1,0, 6));
    tbl.push_back(mk(1,1, 5,0, 0, 32'h22,        2,1,1, 6));
    tbl.push_back(mk(0,0, 0,0, 0, 32'h0,         6,1,0, 6));
    tbl.push_back(mk(0,0, 0,0, 0, 32'hA000_0005, 6,1,1, 6));
    tbl.push_back(mk(0,1, 5,1, 9, 32'hA000_0006, 7,1,1, 7));
    tbl.push_back(mk(0,0, 0,1,12, 32'h0,        10,1,0, 7));
    tbl.push_back(mk(1,0, 0,0, 0, 32'h0,        13,0,0, 7));
    tbl.push_back(mk(0,0, 0,0, 0, 32'hA000_000C,13,1,1, 7));
    tbl.push_back(mk(0,0, 0,1,30, 32'hA000_000D,14,1,1, 8));
    tbl.push_back(mk(0,0, 0,0, 0, 32'h0,        31,1,0, 8));
    tbl.push_back(mk(0,0, 0,0, 0, 32'hA000_001E,31,1,1, 8));
    tbl.push_back(mk(0,0, 0,0, 0, 32'hA000_001F, 0,1,1, 9));
    tbl.push_back(mk(0,0, 0,0, 0, 32'h11,        1,1,1,10));
    tbl.push_back(mk(1,0, 0,0, 0, 32'h22,        2,0,1,11));

    // Program load while the core is held in reset.
    tick();
    for (int i = 0; i < 32; i++) begin
      imem_we = 1'b1; imem_waddr = i[4:0]; imem_wdata = mem_init(i);
      tick();
    end
    imem_we = 1'b0;
    stall = 1'b1;
    #2;
    chk_out("reset", 32'h0, 5'd0, 1'b1, 1'b0, 16'd0);
    tick();
    stall = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      stall = tbl[i].stall; branch_taken = tbl[i].br; branch_target = tbl[i].bt;
      jump = tbl[i].jmp; jump_target = tbl[i].jt;
      #2;
      chk_out($sformatf("vec%0d", i), tbl[i].instr, tbl[i].pcn, tbl[i].en,
              tbl[i].val, tbl[i].cnt);
      tick();
    end

    // Write to the address being fetched: old word now, new word after the edge.
    stall = 1'b1; branch_taken = 1'b0; jump = 1'b0;
    imem_we = 1'b1; imem_waddr = 5'd1; imem_wdata = 32'hDEAD_BEEF;
    #2;
    chk("wr_same_cycle", instruccion, 32'h22);
    tick();
    imem_we = 1'b0;
    #1;
    chk("wr_next_cycle", instruccion, 32'hDEAD_BEEF);

    // Reach pc=7 then reset with a jump pending.
    stall = 1'b0; jump = 1'b1; jump_target = 5'd7;
    tick();
    jump = 1'b0;
    tick();
    #1;
    chk("pc7_instr", instruccion, 32'hA000_0007);
    reset = 1'b0; jump = 1'b1; jump_target = 5'd20;
    #1;
    chk_out("rst_mid", 32'h0, 5'd0, 1'b1, 1'b0, 16'd11);
    tick();
    reset = 1'b1; jump = 1'b0;
    #2;
    chk_out("boot2", 32'h0, 5'd1, 1'b1, 1'b0, 16'd0);
    tick();
    #1;
    chk("run_pc0", instruccion, 32'h11);
    repeat (10) tick();
    #1;
    chk("cnt_after10", {16'd0, fetch_count}, 32'd10);
    chk("instr_pc10", instruccion, 32'hA000_000A);
    chk("cnt_saturated", {29'd0, s_cnt}, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
